// File: rtl/run_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_stream_pkg
// Description : Shared constants and types for the run_stream_tx transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package run_stream_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int STATE_W   = 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/run_stream_tx_piso.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift
// Description : Parallel-in serial-out register, MSB first, zero fill.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift
    import run_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             msb
);

    logic [WIDTH-1:0] r_sreg;

    // A parallel load wins over a shift in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg <= '0;
        end else if (load) begin
            r_sreg <= data_in;
        end else if (shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = r_sreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/run_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : run_stream_tx
// Description : Serialises words MSB-first onto w and predicts the run detector z.
// Revision    : 1.0 - initial release
// ============================================================================
module run_stream_tx
    import run_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             abort,
    output logic             ready,
    output logic             w,
    output logic             w_valid,
    output logic             frame_done,
    output logic             z_expect
);

    localparam int              CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             w_accept, w_shift, w_last, w_msb;
    logic             r_hv, r_hb, r_z;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // abort outranks load in both states.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_last      = 1'b0;
        ready       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (load && !abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                    w_count_nxt = C_CNT_LAST;
                end
            end
            ST_SHIFT: begin
                w_last  = (r_count == '0);
                ready   = w_last;
                w_shift = 1'b1;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    if (load) begin
                        w_accept    = 1'b1;
                        w_count_nxt = C_CNT_LAST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .load    (w_accept),
        .shift   (w_shift),
        .data_in (data_in),
        .msb     (w_msb)
    );

    // Both terms are flop outputs; gating keeps w low after an abort leaves residue.
    assign w_valid    = (r_state == ST_SHIFT);
    assign w          = w_valid & w_msb;
    assign frame_done = w_last;

    // Detector model: restarts whenever the stream goes idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hv <= 1'b0;
            r_hb <= 1'b0;
            r_z  <= 1'b0;
        end else if (w_valid) begin
            r_z  <= r_hv & (r_hb == w);
            r_hb <= w;
            r_hv <= 1'b1;
        end else begin
            r_z  <= 1'b0;
            r_hv <= 1'b0;
        end
    end

    assign z_expect = r_z;

endmodule
`default_nettype wire

// File: tb/tb_run_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_stream_tx
// Description : Directed and loop-back checks for run_stream_tx (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_stream_tx;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       load    = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, w, w_valid, frame_done, z_expect;
    logic [4:0] vec;

    int checks = 0;
    int errors = 0;

    logic       ev  [0:511];
    logic       ew  [0:511];
    logic       el  [0:511];
    logic       ld  [0:511];
    logic [7:0] ldd [0:511];

    run_stream_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .abort      (abort),
        .ready      (ready),
        .w          (w),
        .w_valid    (w_valid),
        .frame_done (frame_done),
        .z_expect   (z_expect)
    );

    always #5 clk = ~clk;

    // {w_valid, w, ready, frame_done, z_expect}
    assign vec = {w_valid, w, ready, frame_done, z_expect};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b0; abort = 1'b0; data_in = 8'h00;
        step(); step();
        checks++;
        if (vec !== 5'b00100) begin
            errors++; $display("FAIL reset_state got=%b exp=%b", vec, 5'b00100);
        end
        reset = 1'b1;
        step();
        data_in = 8'hA5; load = 1'b1;
        step();
        load = 1'b0; data_in = 8'h00;
        step(); step();
        checks++;
        if ({w_valid, w} !== 2'b11) begin
            errors++; $display("FAIL pre_reset_bit3 got=%b exp=%b", {w_valid, w}, 2'b11);
        end
        step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (vec !== 5'b00100) begin
            errors++; $display("FAIL reset_midword got=%b exp=%b", vec, 5'b00100);
        end
        step(); step();
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (vec !== 5'b00100) begin
                errors++; $display("FAIL reset_release_idle cyc=%0d got=%b exp=%b", i, vec, 5'b00100);
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] pat;
        logic [4:0] exp;
        pat = 8'hA5;
        step(); step();
        data_in = pat; load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            load = 1'b0; data_in = 8'($urandom);
            exp = {1'b1, pat[8-i], (i == 8), (i == 8), (i == 6)};
            checks++;
            if (vec !== exp) begin
                errors++; $display("FAIL a5_bit%0d got=%b exp=%b", i, vec, exp);
            end
        end
        step();
        checks++;
        if (vec !== 5'b00100) begin
            errors++; $display("FAIL a5_after got=%b exp=%b", vec, 5'b00100);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bpat, zpat;
        logic [4:0]  exp;
        bpat = 16'hF00F;
        zpat = 16'h3BFB;
        step(); step();
        data_in = 8'hF0; load = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp = {1'b1, bpat[16-i], (i == 8 || i == 16), (i == 8 || i == 16), zpat[16-i]};
            checks++;
            if (vec !== exp) begin
                errors++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, vec, exp);
            end
            if (i == 8) begin
                load = 1'b1; data_in = 8'h0F;
            end else begin
                load = 1'b0; data_in = 8'($urandom);
            end
        end
        step();
        checks++;
        if (vec !== 5'b00101) begin
            errors++; $display("FAIL b2b_tail got=%b exp=%b", vec, 5'b00101);
        end
        step();
        checks++;
        if (vec !== 5'b00100) begin
            errors++; $display("FAIL b2b_idle got=%b exp=%b", vec, 5'b00100);
        end
    endtask

    task automatic test_abort();
        step(); step();
        data_in = 8'hFF; load = 1'b1;
        step();
        load = 1'b0;
        step(); step(); step();
        checks++;
        if (vec !== 5'b11001) begin
            errors++; $display("FAIL abort_bit4 got=%b exp=%b", vec, 5'b11001);
        end
        abort = 1'b1; load = 1'b1; data_in = 8'h3C;
        step();
        checks++;
        if (vec !== 5'b00101) begin
            errors++; $display("FAIL abort_next got=%b exp=%b", vec, 5'b00101);
        end
        abort = 1'b0; load = 1'b1; data_in = 8'h80;
        step();
        load = 1'b0;
        checks++;
        if (vec !== 5'b11000) begin
            errors++; $display("FAIL abort_80_bit1 got=%b exp=%b", vec, 5'b11000);
        end
        step();
        checks++;
        if (vec !== 5'b10000) begin
            errors++; $display("FAIL abort_hist_clear got=%b exp=%b", vec, 5'b10000);
        end
        step();
        checks++;
        if (vec !== 5'b10000) begin
            errors++; $display("FAIL abort_80_bit3 got=%b exp=%b", vec, 5'b10000);
        end
        step();
        checks++;
        if (vec !== 5'b10001) begin
            errors++; $display("FAIL abort_80_bit4 got=%b exp=%b", vec, 5'b10001);
        end
        step(); step(); step(); step();
        checks++;
        if (vec !== 5'b10111) begin
            errors++; $display("FAIL abort_80_last got=%b exp=%b", vec, 5'b10111);
        end
        step();
        checks++;
        if (vec !== 5'b00101) begin
            errors++; $display("FAIL abort_80_tail got=%b exp=%b", vec, 5'b00101);
        end
        step();
        abort = 1'b1; load = 1'b1; data_in = 8'hFF;
        step();
        abort = 1'b0; load = 1'b0;
        checks++;
        if (vec !== 5'b00100) begin
            errors++; $display("FAIL abort_in_idle got=%b exp=%b", vec, 5'b00100);
        end
        step();
    endtask

    task automatic test_load_ignored();
        logic [7:0] pat;
        logic [4:0] exp;
        pat = 8'hA5;
        step(); step();
        data_in = pat; load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = {1'b1, pat[8-i], (i == 8), (i == 8), (i == 6)};
            checks++;
            if (vec !== exp) begin
                errors++; $display("FAIL busy_load_bit%0d got=%b exp=%b", i, vec, exp);
            end
            load = (i == 2 || i == 5);
            data_in = 8'h00;
        end
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (vec !== 5'b00100) begin
                errors++; $display("FAIL busy_load_after%0d got=%b exp=%b", i, vec, 5'b00100);
            end
        end
    endtask

    task automatic test_loopback();
        int         n;
        int         gap;
        logic [7:0] word;
        logic       zx;
        logic [4:0] exp;
        for (int t = 0; t < 512; t++) begin
            ev[t] = 1'b0; ew[t] = 1'b0; el[t] = 1'b0; ld[t] = 1'b0; ldd[t] = 8'h00;
        end
        n = 1;
        for (int wi = 0; wi < 20; wi++) begin
            gap  = int'($urandom_range(0, 3));
            if (wi == 0 && gap == 0) gap = 1;
            word = 8'($urandom);
            for (int g = 0; g < gap; g++) n++;
            ld[n-1]  = 1'b1;
            ldd[n-1] = word;
            for (int b = 0; b < 8; b++) begin
                ev[n] = 1'b1;
                ew[n] = word[7-b];
                el[n] = (b == 7);
                n++;
            end
        end
        n = n + 3;
        step(); step(); step();
        for (int t = 0; t < n; t++) begin
            if (t > 0) step();
            zx  = (t >= 2) && ev[t-1] && ev[t-2] && (ew[t-1] == ew[t-2]);
            exp = {ev[t], ev[t] & ew[t], !ev[t] || el[t], ev[t] & el[t], zx};
            checks++;
            if (vec !== exp) begin
                errors++; $display("FAIL loopback cyc=%0d got=%b exp=%b", t, vec, exp);
            end
            load    = ld[t];
            data_in = ld[t] ? ldd[t] : 8'($urandom);
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort();
        test_load_ignored();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/run_stream_tx.md
Name: run_stream_tx

Overview:
- Serial pattern transmitter that drives the single-bit `w` stream consumed by the run-length (two-equal-in-a-row) detector FSM.
- Accepts parallel words through a ready/load handshake and shifts them out MSB-first, one bit per clock.
- Produces `z_expect`, a cycle-aligned prediction of the detector's `z`, so the pair can be self-checked on the board and in simulation.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit `data_in`; accepted when load & ready at a clk edge.
- abort  input  1  synchronous; ends the current word immediately.
- ready  output  1  block can accept a word this cycle.
- w  output  1  serial bit to the detector (registered).
- w_valid  output  1  `w` carries a live bit this cycle (registered).
- frame_done  output  1  one-cycle pulse during the final bit of a word.
- z_expect  output  1  predicted detector `z` (registered).

Behaviour:
- Reset (async, any time including mid-word): state=IDLE, w=0, w_valid=0, frame_done=0, z_expect=0, ready=1, history cleared.
- States: IDLE and SHIFT. Encodings are defined as constants in the package.
- IDLE:
  - ready=1, w_valid=0, w=0.
  - If load at an edge: capture `data_in`, go to SHIFT. The next cycle shows w=data_in[WIDTH-1], w_valid=1. Latency from load to first bit is 1 cycle.
- SHIFT:
  - Each edge shifts left by one. A bit counter runs from WIDTH-1 down to 0.
  - w_valid=1 for exactly WIDTH consecutive cycles per word.
  - ready=0, except in the last-bit cycle (count==0), where ready=1.
- Last-bit cycle (count==0):
  - frame_done=1 (combinational from state and count).
  - load=1: capture the new word and stay in SHIFT. The next cycle is the new MSB, with no gap (back-to-back).
  - load=0: go to IDLE.
- abort:
  - In SHIFT, abort at an edge forces IDLE. Next cycle w=0, w_valid=0, and history is cleared.
  - abort has priority over load in the same cycle.
  - abort in IDLE has no effect (a concurrent load is still dropped: abort wins).
- History / z_expect (mirrors the detector, which restarts at its initial state):
  - hv (history valid) and hb (last bit) are registers.
  - At each edge where w_valid=1: z_expect <= hv & (hb == w); hb <= w; hv <= 1.
  - At each edge where w_valid=0: z_expect <= 0; hv <= 0.
  - History persists across back-to-back words and clears on any idle cycle.
- data_in is ignored whenever load is not accepted. load while ready=0 is dropped; no queuing.

Decomposition:
- Package run_stream_pkg: state constants (ST_IDLE, ST_SHIFT), WIDTH default, counter width = clog2(WIDTH).
- Sub-module piso_shift (parallel-in serial-out register, WIDTH-parameterised) with ports clk, reset, load, shift, data_in, msb.
- The FSM, counter and history logic stay in run_stream_tx.

Test Plan:
- Reset held low mid-word (after 3 bits of 8'hA5) -> w=0, w_valid=0, ready=1, z_expect=0 immediately; release and idle stays quiet.
- load 8'hA5 -> w over 8 cycles = 1,0,1,0,0,1,0,1; frame_done on the 8th bit; z_expect=1 only in the cycle after the 5th bit (the 0,0 pair).
- load 8'hF0 then load 8'h0F on its last-bit cycle -> 16 contiguous valid bits 1111000000001111, ready=1 only in bit cycles 8 and 16; z_expect stays high across the word boundary (0,0 run).
- abort during bit 4 of 8'hFF with load=1 also asserted -> next cycle w_valid=0, state IDLE, word not captured; a subsequent load of 8'h80 gives z_expect=0 on its first bit (history cleared).
- load asserted while ready=0 (mid-word) -> ignored; output stream identical to the run without it.
- Loop-back with the detector instance on the same clk and reset, random words with random gaps -> detector z equals z_expect every cycle.
